// File: rtl/freq_lock_pkg.sv
// Shared widths, lock-detector state encoding and the stage-1 payload of the PI loop.
package freq_lock_pkg;

    localparam int unsigned ERR_W = 17;
    localparam int unsigned ABS_W = ERR_W + 1;
    localparam int unsigned FW_W  = 24;
    localparam int unsigned INT_W = 32;
    localparam int unsigned SUM_W = 34;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_HOLD   = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic [INT_W-1:0] p;
        logic [INT_W-1:0] i_cand;
        logic             pos;
        logic             neg;
    } pi_stage_t;

    // Magnitude in one extra bit so that -2^16 maps to +2^16 instead of wrapping.
    function automatic logic [ABS_W-1:0] err_abs(input logic [ERR_W-1:0] e);
        logic [ABS_W-1:0] x;
        x = {e[ERR_W-1], e};
        return e[ERR_W-1] ? (~x + ABS_W'(1)) : x;
    endfunction

endpackage

// File: rtl/freq_lock_pi_if.sv
// Sample/command bus between the loop filter, PI controller and NCO.
interface freq_lock_pi_if;
    import freq_lock_pkg::*;

    logic             en;
    logic [ERR_W-1:0] err;
    logic             hold;
    logic [FW_W-1:0]  freq_word;
    logic             valid_out;
    logic             locked;
    logic             sat;
    logic [1:0]       state;

    modport master (output en, err, hold,
                    input  freq_word, valid_out, locked, sat, state);
    modport slave  (input  en, err, hold,
                    output freq_word, valid_out, locked, sat, state);
endinterface

// File: rtl/freq_lock_detect.sv
// Lock detector: |err| window compare, hit/miss run counters and ACQ/LOCKED/HOLD FSM.
module freq_lock_detect
    import freq_lock_pkg::*;
#(
    parameter logic [ERR_W-1:0] LOCK_TH    = 17'd256,
    parameter int unsigned      LOCK_CNT   = 1024,
    parameter int unsigned      UNLOCK_CNT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             hold,
    input  logic [ERR_W-1:0] err,
    output lock_state_e      state,
    output logic             locked,
    output logic             acq
);

    localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);

    lock_state_e       state_d;
    logic [HIT_W-1:0]  hit_q,  hit_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              in_win;

    assign in_win = err_abs(err) <= ABS_W'(LOCK_TH);

    // Next state; a run counter that reaches its target moves the FSM and clears, so it never wraps.
    always_comb begin
        state_d = state;
        hit_d   = hit_q;
        miss_d  = miss_q;
        if (hold) begin
            state_d = ST_HOLD;
            hit_d   = '0;
            miss_d  = '0;
        end else begin
            case (state)
                ST_ACQ: if (en) begin
                    if (!in_win) begin
                        hit_d = '0;
                    end else if (hit_q >= HIT_W'(LOCK_CNT - 1)) begin
                        state_d = ST_LOCKED;
                        hit_d   = '0;
                    end else begin
                        hit_d = hit_q + HIT_W'(1);
                    end
                end
                ST_LOCKED: if (en) begin
                    if (in_win) begin
                        miss_d = '0;
                    end else if (miss_q >= MISS_W'(UNLOCK_CNT - 1)) begin
                        state_d = ST_ACQ;
                        miss_d  = '0;
                    end else begin
                        miss_d = miss_q + MISS_W'(1);
                    end
                end
                ST_HOLD: state_d = ST_ACQ;
                default: state_d = ST_ACQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_ACQ;
            hit_q  <= '0;
            miss_q <= '0;
            locked <= 1'b0;
            acq    <= 1'b1;
        end else begin
            state  <= state_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            locked <= (state_d == ST_LOCKED);
            acq    <= (state_d == ST_ACQ);
        end
    end

endmodule

// File: rtl/freq_lock_pi.sv
// PI frequency controller: 2-stage pipeline from filtered phase error to clamped NCO word, with anti-windup.
module freq_lock_pi
    import freq_lock_pkg::*;
#(
    parameter int unsigned      KP_SHIFT   = 4,
    parameter int unsigned      KI_SHIFT   = 10,
    parameter logic [FW_W-1:0]  F_CENTER   = 24'd8388608,
    parameter logic [FW_W-1:0]  F_MIN      = 24'd4194304,
    parameter logic [FW_W-1:0]  F_MAX      = 24'd12582912,
    parameter logic [ERR_W-1:0] LOCK_TH    = 17'd256,
    parameter int unsigned      LOCK_CNT   = 1024,
    parameter int unsigned      UNLOCK_CNT = 64
) (
    input logic           clk,
    input logic           rst,
    freq_lock_pi_if.slave bus
);

    localparam logic signed [SUM_W-1:0] CENTER_S = SUM_W'(F_CENTER);
    localparam logic signed [SUM_W-1:0] FMIN_S   = SUM_W'(F_MIN);
    localparam logic signed [SUM_W-1:0] FMAX_S   = SUM_W'(F_MAX);

    lock_state_e state;
    logic        locked;
    logic        acq;

    freq_lock_detect #(
        .LOCK_TH   (LOCK_TH),
        .LOCK_CNT  (LOCK_CNT),
        .UNLOCK_CNT(UNLOCK_CNT)
    ) u_detect (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .hold  (bus.hold),
        .err   (bus.err),
        .state (state),
        .locked(locked),
        .acq   (acq)
    );

    logic                    accept;
    logic signed [INT_W-1:0] err_ext;
    logic signed [INT_W-1:0] p_c;
    logic signed [INT_W-1:0] integ, integ_new, integ_fwd;
    logic signed [INT_W:0]   i_wide;
    logic        [INT_W-1:0] i_cand;
    pi_stage_t               s1, s1_d;
    logic                    s1_vld;
    logic signed [INT_W-1:0] s1_icand_s, i_scaled;
    logic signed [SUM_W-1:0] sum;
    logic                    hi, lo;
    logic [FW_W-1:0]         clamp_c;
    logic [FW_W-1:0]         freq_q;
    logic                    valid_q, sat_q;

    // hold beats a simultaneous sample; nothing enters the pipe while frozen.
    assign accept  = bus.en & ~bus.hold & (state != ST_HOLD);
    assign err_ext = {{(INT_W-ERR_W){bus.err[ERR_W-1]}}, bus.err};
    assign p_c     = acq ? (err_ext >>> (KP_SHIFT - 1)) : (err_ext >>> KP_SHIFT);

    // Stage 1 sees the integrator value stage 2 is committing this cycle, so back-to-back samples chain correctly.
    assign integ_fwd = s1_vld ? integ_new : integ;
    assign i_wide    = {integ_fwd[INT_W-1], integ_fwd} + {err_ext[INT_W-1], err_ext};

    always_comb begin
        i_cand = i_wide[INT_W-1:0];
        if (i_wide[INT_W] != i_wide[INT_W-1]) begin
            i_cand = i_wide[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
        end
    end

    always_comb begin
        s1_d        = '0;
        s1_d.p      = p_c;
        s1_d.i_cand = i_cand;
        s1_d.pos    = ~bus.err[ERR_W-1] & (|bus.err);
        s1_d.neg    = bus.err[ERR_W-1];
    end

    // Stage 2: centre + P + scaled I in 34 bits, then clamp and anti-windup.
    assign s1_icand_s = s1.i_cand;
    assign i_scaled   = s1_icand_s >>> KI_SHIFT;
    assign sum        = CENTER_S
                      + {{(SUM_W-INT_W){s1.p[INT_W-1]}}, s1.p}
                      + {{(SUM_W-INT_W){i_scaled[INT_W-1]}}, i_scaled};
    assign hi         = sum > FMAX_S;
    assign lo         = sum < FMIN_S;
    assign clamp_c    = hi ? F_MAX : (lo ? F_MIN : sum[FW_W-1:0]);
    assign integ_new  = ((hi && s1.pos) || (lo && s1.neg)) ? integ : s1_icand_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1      <= '0;
            integ   <= '0;
            freq_q  <= F_CENTER;
            valid_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            s1_vld  <= accept;
            if (accept) s1 <= s1_d;
            valid_q <= s1_vld;
            if (s1_vld) begin
                integ  <= integ_new;
                freq_q <= clamp_c;
                sat_q  <= hi | lo;
            end
        end
    end

    assign bus.freq_word = freq_q;
    assign bus.valid_out = valid_q;
    assign bus.locked    = locked;
    assign bus.sat       = sat_q;
    assign bus.state     = state;

endmodule

// File: tb/tb_freq_lock_pi.sv
// Directed bench for freq_lock_pi: single-sample response table plus lock, unlock, saturation and hold sequences.
module tb_freq_lock_pi;
    import freq_lock_pkg::*;

    localparam logic [FW_W-1:0] FC  = 24'd8388608;
    localparam logic [FW_W-1:0] FMN = 24'd8355840;
    localparam logic [FW_W-1:0] FMX = 24'd8421376;

    typedef struct {
        logic [ERR_W-1:0] err;
        logic [FW_W-1:0]  freq;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_run;
    int   n_fail;
    vec_t vecs[10];

    always #5 clk = ~clk;

    freq_lock_pi_if bus();

    // Clamp window narrowed to +/-32768 around centre so saturation is reachable quickly.
    freq_lock_pi #(.F_MIN(FMN), .F_MAX(FMX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.hold = 1'b0;
        bus.err  = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic sample(input logic [ERR_W-1:0] e);
        bus.en  = 1'b1;
        bus.err = e;
        tick();
        bus.en  = 1'b0;
    endtask

    initial begin
        n_run    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.en   = 1'b0;
        bus.hold = 1'b0;
        bus.err  = '0;

        // Response of an empty integrator in ACQ: FC + (err>>>3) + (err>>>10).
        vecs[0] = '{17'(1600),   24'd8388809};
        vecs[1] = '{17'(0),      24'd8388608};
        vecs[2] = '{17'(-1),     24'd8388606};
        vecs[3] = '{17'(-1600),  24'd8388406};
        vecs[4] = '{17'(7),      24'd8388608};
        vecs[5] = '{17'(-8),     24'd8388606};
        vecs[6] = '{17'(65535),  24'd8396862};
        vecs[7] = '{17'(-65536), 24'd8380352};
        vecs[8] = '{17'(1024),   24'd8388737};
        vecs[9] = '{17'(-1025),  24'd8388477};

        tick();
        tick();
        rst = 1'b0;
        check("rst_freq",   32'(bus.freq_word), 32'(FC));
        check("rst_locked", 32'(bus.locked),    0);
        check("rst_sat",    32'(bus.sat),       0);
        check("rst_state",  32'(bus.state),     0);
        check("rst_valid",  32'(bus.valid_out), 0);

        for (int i = 0; i < 10; i++) begin
            do_reset();
            sample(vecs[i].err);
            check("vec_valid_k1", 32'(bus.valid_out), 0);
            tick();
            check("vec_freq",     32'(bus.freq_word), 32'(vecs[i].freq));
            check("vec_valid_k2", 32'(bus.valid_out), 1);
            check("vec_sat",      32'(bus.sat),       0);
            tick();
            check("vec_valid_k3", 32'(bus.valid_out), 0);
        end

        // Back-to-back: second sample must see the first one's integrator update.
        do_reset();
        sample(17'(1600));
        check("b2b_valid0", 32'(bus.valid_out), 0);
        sample(17'(1600));
        check("b2b_freq1",  32'(bus.freq_word), 8388809);
        check("b2b_valid1", 32'(bus.valid_out), 1);
        tick();
        check("b2b_freq2",  32'(bus.freq_word), 8388811);
        check("b2b_valid2", 32'(bus.valid_out), 1);
        tick();
        check("b2b_valid3", 32'(bus.valid_out), 0);

        // Reset with a sample in flight drops it.
        do_reset();
        sample(17'(1600));
        rst = 1'b1;
        tick();
        check("midrst_valid", 32'(bus.valid_out), 0);
        check("midrst_freq",  32'(bus.freq_word), 32'(FC));
        rst = 1'b0;
        tick();
        check("midrst_valid2", 32'(bus.valid_out), 0);
        check("midrst_freq2",  32'(bus.freq_word), 32'(FC));

        // Lock: a miss after 1023 hits restarts the count; then 1024 hits at the +/-256 window edge.
        do_reset();
        repeat (1023) sample(17'(100));
        sample(17'(300));
        check("lock_miss_state",  32'(bus.state),  0);
        check("lock_miss_locked", 32'(bus.locked), 0);
        for (int i = 0; i < 1023; i++) sample((i % 2 == 0) ? 17'(256) : 17'(-256));
        check("lock_1023_locked", 32'(bus.locked), 0);
        sample(17'(100));
        check("lock_1024_locked", 32'(bus.locked), 1);
        check("lock_1024_state",  32'(bus.state),  1);

        // Unlock: 63 misses then a hit keeps lock; 64 misses (257 and -65536 count as out) drop it.
        repeat (63) sample(17'(1000));
        check("unl_63_locked", 32'(bus.locked), 1);
        sample(17'(0));
        check("unl_hit_locked", 32'(bus.locked), 1);
        check("unl_hit_state",  32'(bus.state),  1);
        repeat (63) sample(17'(257));
        check("unl_63b_locked", 32'(bus.locked), 1);
        sample(17'(-65536));
        check("unl_64_locked", 32'(bus.locked), 0);
        check("unl_64_state",  32'(bus.state),  0);

        // Saturation and anti-windup: integrator parks at 384*65535, so -100 leaves the clamp at once.
        do_reset();
        repeat (5000) sample(17'(65535));
        tick();
        tick();
        check("sat_freq", 32'(bus.freq_word), 32'(FMX));
        check("sat_flag", 32'(bus.sat),       1);
        sample(17'(-100));
        tick();
        check("sat_rel_freq",  32'(bus.freq_word), 8413170);
        check("sat_rel_flag",  32'(bus.sat),       0);
        check("sat_rel_valid", 32'(bus.valid_out), 1);

        // Hold with en streaming: two samples land (8388670 each), then the loop freezes.
        do_reset();
        bus.en  = 1'b1;
        bus.err = 17'(500);
        tick();
        tick();
        bus.hold = 1'b1;
        tick();
        check("hold_state", 32'(bus.state), 2);
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check("hold_freq",  32'(bus.freq_word), 8388670);
            check("hold_valid", 32'(bus.valid_out), 0);
            tick();
        end
        bus.hold = 1'b0;
        tick();
        check("rel_state", 32'(bus.state), 0);
        tick();
        tick();
        check("rel_valid", 32'(bus.valid_out), 1);
        check("rel_freq",  32'(bus.freq_word), 8388671);
        bus.en = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
